// File: rtl/fb_pkg.sv
// Shared constants, state encoding and address helper for the framebuffer scheduler.
package fb_pkg;

  localparam int          SCREEN_W  = 640;
  localparam int          SCREEN_H  = 480;
  localparam int          PIXELS    = SCREEN_W * SCREEN_H;
  localparam logic [19:0] BUF0_BASE = 20'h00000;
  localparam logic [19:0] BUF1_BASE = 20'h4B000;
  localparam int          ENTRY_W   = 36;

  typedef enum logic [1:0] {
    CLEAR     = 2'd0,
    DRAW      = 2'd1,
    DRAIN     = 2'd2,
    SWAP_WAIT = 2'd3
  } fb_state_e;

  // Row start offset y*w in 20 bits; the 640-wide case is two shifts and an add.
  function automatic logic [19:0] row_offset(input logic [9:0] y, input int w);
    logic [19:0] y20;
    y20 = {10'd0, y};
    if (w == 640) row_offset = (y20 << 9) + (y20 << 7);
    else          row_offset = y20 * 20'(w);
  endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO holding {sram address, colour} entries awaiting an SRAM grant.
module pixel_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = fb_pkg::ENTRY_W
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer update; the extra MSB distinguishes full from empty.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because the pointers gate visibility.
  always_ff @(posedge Clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[PW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);

endmodule

// File: rtl/framebuffer_scheduler.sv
// Double-buffered framebuffer write scheduler: clears the back buffer, queues
// rasterizer pixels into SRAM writes, drains, then swaps buffers in vblank.
module framebuffer_scheduler #(
  parameter int          SCREEN_W   = fb_pkg::SCREEN_W,
  parameter int          SCREEN_H   = fb_pkg::SCREEN_H,
  parameter logic [19:0] BUF0_BASE  = fb_pkg::BUF0_BASE,
  parameter logic [19:0] BUF1_BASE  = fb_pkg::BUF1_BASE,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic [15:0] pix_color,
  input  logic [15:0] clear_color,
  input  logic        frame_done,
  input  logic        vblank,
  input  logic        sram_grant,
  output logic        sram_we,
  output logic [19:0] sram_addr,
  output logic [15:0] sram_data,
  output logic [19:0] front_base,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  import fb_pkg::*;

  localparam int          PIXELS_L = SCREEN_W * SCREEN_H;
  localparam logic [19:0] LAST_CNT = 20'(PIXELS_L - 1);

  fb_state_e   state;
  logic [19:0] cnt;
  logic [19:0] back_base;
  logic [19:0] pix_addr;
  logic [35:0] fifo_head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        pix_fire;
  logic        in_range;
  logic        write_pending;

  assign back_base = (front_base == BUF0_BASE) ? BUF1_BASE : BUF0_BASE;

  // Pixel handshake: a pixel transfers in any cycle where pix_valid and
  // pix_ready are both high; pix_ready never depends on pix_valid and is only
  // raised in DRAW while the queue has room. Out-of-screen pixels still
  // transfer but are dropped instead of queued.
  assign pix_ready = Reset_n && (state == DRAW) && !fifo_full;
  assign pix_fire  = pix_valid && pix_ready;
  assign in_range  = ({22'd0, pix_x} < 32'(SCREEN_W)) && ({22'd0, pix_y} < 32'(SCREEN_H));
  assign pix_addr  = back_base + row_offset(pix_y, SCREEN_W) + {10'd0, pix_x};
  assign fifo_push = pix_fire && in_range;

  // A write is pending throughout CLEAR, and in DRAW/DRAIN while pixels are queued.
  assign write_pending = (state == CLEAR) ||
                         (((state == DRAW) || (state == DRAIN)) && !fifo_empty);
  assign sram_we   = Reset_n && sram_grant && write_pending;
  assign fifo_pop  = sram_we && (state != CLEAR);
  assign busy      = !Reset_n || (state != DRAW);
  assign state_dbg = state;

  // SRAM write data path; bus is held at zero whenever no write is issued.
  always_comb begin
    sram_addr = '0;
    sram_data = '0;
    if (sram_we) begin
      if (state == CLEAR) begin
        sram_addr = back_base + cnt;
        sram_data = clear_color;
      end else begin
        sram_addr = fifo_head[35:16];
        sram_data = fifo_head[15:0];
      end
    end
  end

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .push      (fifo_push),
    .push_data ({pix_addr, pix_color}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Frame sequencing: clear counter, buffer ownership and state transitions.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state      <= CLEAR;
      cnt        <= '0;
      front_base <= BUF0_BASE;
    end else begin
      case (state)
        CLEAR: begin
          if (sram_we) begin
            if (cnt == LAST_CNT) begin
              cnt   <= '0;
              state <= DRAW;
            end else begin
              cnt <= cnt + 20'd1;
            end
          end
        end
        DRAW: begin
          if (frame_done) state <= DRAIN;
        end
        DRAIN: begin
          if (fifo_empty) state <= SWAP_WAIT;
        end
        SWAP_WAIT: begin
          if (vblank) begin
            front_base <= back_base;
            cnt        <= '0;
            state      <= CLEAR;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_scheduler.sv
// Directed bench for framebuffer_scheduler: 640-wide rows, 4-row screen so
// full clears stay short while the 640-column address arithmetic is exercised.
module tb_framebuffer_scheduler;

  localparam int PIX = 640 * 4;

  logic        Clk;
  logic        Reset_n;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [15:0] pix_color;
  logic [15:0] clear_color;
  logic        frame_done;
  logic        vblank;
  logic        sram_grant;
  logic        sram_we;
  logic [19:0] sram_addr;
  logic [15:0] sram_data;
  logic [19:0] front_base;
  logic        busy;
  logic [1:0]  state_dbg;

  int errors = 0;
  int checks = 0;
  logic [35:0] exp_q[$];

  framebuffer_scheduler #(
    .SCREEN_W   (640),
    .SCREEN_H   (4),
    .BUF0_BASE  (20'h00000),
    .BUF1_BASE  (20'h4B000),
    .FIFO_DEPTH (4)
  ) dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_color   (pix_color),
    .clear_color (clear_color),
    .frame_done  (frame_done),
    .vblank      (vblank),
    .sram_grant  (sram_grant),
    .sram_we     (sram_we),
    .sram_addr   (sram_addr),
    .sram_data   (sram_data),
    .front_base  (front_base),
    .busy        (busy),
    .state_dbg   (state_dbg)
  );

  // Clock and watchdog
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_write(input string tag);
    logic [35:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=write expected=queue entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {27'd0, sram_we, sram_addr, sram_data}, {27'd0, 1'b1, e});
    end
  endtask

  task automatic next_cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive_pix(input logic v, input logic [9:0] x, input logic [9:0] y,
                           input logic [15:0] c);
    pix_valid = v;
    pix_x     = x;
    pix_y     = y;
    pix_color = c;
  endtask

  initial begin
    int exp_cnt;
    int cycles;
    logic g;

    Reset_n     = 1'b0;
    sram_grant  = 1'b1;
    clear_color = 16'h1234;
    frame_done  = 1'b0;
    vblank      = 1'b0;
    drive_pix(1'b0, 10'd0, 10'd0, 16'd0);

    // Reset state
    next_cycle();
    next_cycle();
    #1;
    chk("rst_ready", pix_ready, 0);
    chk("rst_we", sram_we, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_data", sram_data, 0);
    chk("rst_busy", busy, 1);
    chk("rst_front", front_base, 20'h00000);

    // Full clear of buffer 1 with constant grant
    Reset_n = 1'b1;
    #1;
    for (int i = 0; i < PIX; i++) begin
      chk("clr1_wr", {busy, pix_ready, sram_we, sram_addr, sram_data},
          {1'b1, 1'b0, 1'b1, 20'h4B000 + 20'(i), 16'h1234});
      @(posedge Clk);
      #2;
    end
    chk("clr1_busy", busy, 0);
    chk("clr1_ready", pix_ready, 1);
    chk("clr1_state", state_dbg, 2'd1);

    // Single pixel (5,2) written the cycle after acceptance
    drive_pix(1'b1, 10'd5, 10'd2, 16'hF800);
    #1;
    chk("px1_ready", pix_ready, 1);
    chk("px1_no_we_same_cycle", sram_we, 0);
    exp_q.push_back({20'h4B505, 16'hF800});
    next_cycle();
    pix_valid = 1'b0;
    #1;
    chk_write("px1_write");
    next_cycle();
    #1;
    chk("px1_idle", sram_we, 0);

    // Queue fills with grant low; fifth pixel waits
    sram_grant = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive_pix(1'b1, 10'(k), 10'd1, 16'hA000 + 16'(k));
      #1;
      chk("fill_ready", pix_ready, 1);
      chk("fill_no_we", sram_we, 0);
      exp_q.push_back({20'h4B280 + 20'(k), 16'hA000 + 16'(k)});
      next_cycle();
    end
    drive_pix(1'b1, 10'd4, 10'd1, 16'hA004);
    #1;
    chk("full_ready", pix_ready, 0);
    next_cycle();
    #1;
    chk("full_ready_hold", pix_ready, 0);
    next_cycle();
    sram_grant = 1'b1;
    #1;
    chk("drain_ready_full", pix_ready, 0);
    chk_write("drain_w0");
    next_cycle();
    #1;
    chk("drain_ready_fifth", pix_ready, 1);
    exp_q.push_back({20'h4B284, 16'hA004});
    chk_write("drain_w1");
    next_cycle();
    pix_valid = 1'b0;
    #1;
    chk_write("drain_w2");
    next_cycle();
    #1;
    chk_write("drain_w3");
    next_cycle();
    #1;
    chk_write("drain_w4");
    next_cycle();
    #1;
    chk("drain_idle", sram_we, 0);

    // Out-of-range pixels complete the handshake but are never written
    drive_pix(1'b1, 10'd640, 10'd0, 16'hBEEF);
    #1;
    chk("oob_x_ready", pix_ready, 1);
    next_cycle();
    drive_pix(1'b1, 10'd0, 10'd4, 16'hBEEF);
    #1;
    chk("oob_x_no_we", sram_we, 0);
    chk("oob_y_ready", pix_ready, 1);
    next_cycle();
    drive_pix(1'b1, 10'd639, 10'd3, 16'h0F0F);
    #1;
    chk("oob_y_no_we", sram_we, 0);
    exp_q.push_back({20'h4B9FF, 16'h0F0F});
    next_cycle();
    pix_valid = 1'b0;
    #1;
    chk_write("corner_write");

    // frame_done with two queued pixels, second accepted in the same cycle
    next_cycle();
    sram_grant = 1'b0;
    drive_pix(1'b1, 10'd1, 10'd3, 16'h1111);
    #1;
    chk("fd_ready0", pix_ready, 1);
    exp_q.push_back({20'h4B781, 16'h1111});
    next_cycle();
    drive_pix(1'b1, 10'd2, 10'd3, 16'h2222);
    frame_done = 1'b1;
    #1;
    chk("fd_ready1", pix_ready, 1);
    exp_q.push_back({20'h4B782, 16'h2222});
    next_cycle();
    frame_done = 1'b0;
    pix_valid  = 1'b0;
    #1;
    chk("drn_state", state_dbg, 2'd2);
    chk("drn_busy", busy, 1);
    chk("drn_ready", pix_ready, 0);
    next_cycle();
    sram_grant = 1'b1;
    #1;
    chk_write("drn_w0");
    next_cycle();
    #1;
    chk_write("drn_w1");
    next_cycle();
    #1;
    chk("drn_empty_we", sram_we, 0);
    next_cycle();
    #1;
    chk("sw_state", state_dbg, 2'd3);
    frame_done = 1'b1;
    next_cycle();
    frame_done = 1'b0;
    next_cycle();
    #1;
    chk("sw_hold_state", state_dbg, 2'd3);
    chk("sw_hold_front", front_base, 20'h00000);
    chk("sw_hold_we", sram_we, 0);
    vblank      = 1'b1;
    clear_color = 16'h5A5A;
    next_cycle();
    vblank = 1'b0;
    #1;
    chk("swap_front", front_base, 20'h4B000);
    chk("swap_state", state_dbg, 2'd0);

    // Clear of buffer 0 with grant alternating 1,0
    exp_cnt = 0;
    cycles  = 0;
    while (exp_cnt < PIX && cycles < 2 * PIX + 16) begin
      g = (cycles % 2 == 0);
      sram_grant = g;
      #1;
      chk("clr2_wr", {sram_we, sram_addr, sram_data},
          g ? {1'b1, 20'(exp_cnt), 16'h5A5A} : 37'd0);
      if (g) exp_cnt++;
      cycles++;
      next_cycle();
    end
    chk("clr2_count", exp_cnt, PIX);
    chk("clr2_cycles", cycles, 2 * PIX - 1);
    sram_grant = 1'b1;
    #1;
    chk("clr2_state", state_dbg, 2'd1);
    chk("clr2_busy", busy, 0);

    // Reset in DRAW with queued pixels: no write in reset cycle, restart clear of buffer 1
    sram_grant = 1'b0;
    drive_pix(1'b1, 10'd7, 10'd0, 16'h7777);
    next_cycle();
    drive_pix(1'b1, 10'd8, 10'd0, 16'h8888);
    next_cycle();
    pix_valid  = 1'b0;
    Reset_n    = 1'b0;
    sram_grant = 1'b1;
    #1;
    chk("rst2_no_write", {sram_we, sram_addr, sram_data, pix_ready, busy},
        {1'b0, 20'd0, 16'd0, 1'b0, 1'b1});
    next_cycle();
    Reset_n = 1'b1;
    #1;
    chk("rst2_state", state_dbg, 2'd0);
    chk("rst2_front", front_base, 20'h00000);
    for (int i = 0; i < PIX; i++) begin
      chk("clr3_wr", {sram_we, sram_addr, sram_data}, {1'b1, 20'h4B000 + 20'(i), 16'h5A5A});
      @(posedge Clk);
      #2;
    end
    chk("clr3_state", state_dbg, 2'd1);
    chk("clr3_fifo_abandoned", sram_we, 0);
    next_cycle();
    #1;
    chk("clr3_fifo_abandoned2", sram_we, 0);
    chk("sb_leftover", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/framebuffer_scheduler.md
FRAMEBUFFER_SCHEDULER -- requirements
Module: framebuffer_scheduler

Interface
REQ-001 SHALL have parameter SCREEN_W, default 640, pixels per row.
REQ-002 SHALL have parameter SCREEN_H, default 480, rows per frame.
REQ-003 SHALL have parameter BUF0_BASE, default 20'h00000, SRAM base of buffer 0.
REQ-004 SHALL have parameter BUF1_BASE, default 20'h4B000, SRAM base of buffer 1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, pixel queue entries (power of 2).
REQ-006 SHALL have port Clk  in  1  single system clock; all logic on its rising edge.
REQ-007 SHALL have port Reset_n  in  1  reset, synchronous, active-low.
REQ-008 SHALL have ports pix_valid in 1 / pix_ready out 1  pixel write handshake.
REQ-009 SHALL have ports pix_x in 10 (column) / pix_y in 10 (row) / pix_color in 16  pixel payload.
REQ-010 SHALL have port clear_color  in  16  fill value for back-buffer clear.
REQ-011 SHALL have port frame_done  in  1  one-cycle pulse: rasterizer finished frame.
REQ-012 SHALL have port vblank  in  1  display in vertical blank; buffer swap permitted.
REQ-013 SHALL have port sram_grant  in  1  SRAM write port available this cycle.
REQ-014 SHALL have ports sram_we out 1 / sram_addr out 20 / sram_data out 16  SRAM write port.
REQ-015 SHALL have port front_base  out  20  base address of displayed buffer.
REQ-016 SHALL have port busy  out  1  high in every state except DRAW.

Function
REQ-017 SHALL implement states CLEAR, DRAW, DRAIN, SWAP_WAIT; back_base is whichever of BUF0/BUF1 is not front_base.
REQ-018 CLEAR: pix_ready=0; each cycle with sram_grant=1 writes clear_color to back_base+cnt, cnt+1; cnt holds when grant=0; after write of cnt=SCREEN_W*SCREEN_H-1 -> DRAW.
REQ-019 DRAW: pix_ready = FIFO not full; transfer when pix_valid&pix_ready; enqueued entry = {back_base + pix_y*SCREEN_W + pix_x, pix_color}.
REQ-020 Address arithmetic SHALL be 20-bit, y*640 as (y<<9)+(y<<7), no multiplier IP.
REQ-021 Pixel with pix_x>=SCREEN_W or pix_y>=SCREEN_H SHALL be accepted (handshake completes) and discarded, never written.
REQ-022 In DRAW and DRAIN, FIFO head SHALL be written and popped in any cycle with sram_grant=1 and FIFO non-empty; pixel accepted cycle N is writable no earlier than N+1.
REQ-023 Simultaneous push and pop on a full FIFO SHALL NOT occur (ready deasserted when full); push+pop otherwise allowed same cycle.
REQ-024 frame_done in DRAW -> DRAIN; a pixel transferred in the same cycle SHALL be enqueued; frame_done in other states ignored.
REQ-025 DRAIN: pix_ready=0; writes continue; FIFO empty -> SWAP_WAIT.
REQ-026 SWAP_WAIT: on vblank=1, front_base <= old back_base (visible next cycle), cnt<=0, -> CLEAR; otherwise hold.
REQ-027 sram_we SHALL equal sram_grant AND a write is pending (combinational); sram_addr, sram_data SHALL be 0 when sram_we=0.
REQ-028 Ordering: SRAM writes SHALL occur in pixel acceptance order.

Reset
REQ-029 While Reset_n=0 at a clock edge: state<=CLEAR, cnt<=0, FIFO emptied, front_base<=BUF0_BASE.
REQ-030 Reset values: pix_ready=0, sram_we=0, sram_addr=0, sram_data=0, busy=1, front_base=BUF0_BASE.
REQ-031 Reset asserted mid-clear or mid-draw SHALL abandon queued pixels and restart clear of BUF1 without any further write in the reset cycle.

Structure
REQ-032 Package fb_pkg SHALL hold SCREEN_W, SCREEN_H, PIXELS, BUF0_BASE, BUF1_BASE constants and the state enum.
REQ-033 Queue SHALL be a sub-module pixel_fifo (synchronous, 36-bit entries, full/empty flags, same Clk/Reset_n).

Verification
REQ-034 Reset, sram_grant=1 constant, clear_color=16'h1234 -> 307200 writes addr 20'h4B000..20'h95FFF data 16'h1234, then busy=0, pix_ready=1.
REQ-035 CLEAR with sram_grant toggling 1,0 -> cnt advances only on grant; 614399 cycles total; no address skipped or repeated.
REQ-036 DRAW, pixel (x=5,y=2,color=16'hF800), grant=1 -> next cycle sram_we=1, addr=20'h4B000+1285=20'h4B505, data=16'hF800.
REQ-037 DRAW, grant=0, 5 pixels offered -> 4 accepted, pix_ready=0; grant=1 -> 4 writes in order, then 5th accepted.
REQ-038 Pixel x=640,y=0 -> handshake completes, no sram_we.
REQ-039 frame_done with 2 queued, vblank=0 -> 2 writes, stays SWAP_WAIT; vblank=1 -> next cycle front_base=20'h4B000, clear of 20'h00000 begins.
